// File: rtl/product_accumulator_pkg.sv
// -----------------------------------------------------------------------------
// product_accumulator_pkg
// Shared typedefs for the datapath FSMs of the product accumulator.
//   acc_state_e : ACCUM collects product terms, DONE holds a finished sum.
// -----------------------------------------------------------------------------
package product_accumulator_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } acc_state_e;

endpackage : product_accumulator_pkg

// File: rtl/product_accumulator_if.sv
// -----------------------------------------------------------------------------
// product_accumulator_if
// Stream bundle between a producer of product terms and the accumulator.
//   clear_i  : synchronous abort of the current group / pending result
//   valid_i, ready_o, data_i : input term handshake (width_p bits)
//   valid_o, ready_i, sum_o  : output sum handshake (sum_w bits)
// Modports: slave = accumulator side, master = producer/consumer side.
// -----------------------------------------------------------------------------
interface product_accumulator_if #(
    parameter int width_p = 8,
    parameter int count_p = 4
);
    localparam int sum_w = width_p + $clog2(count_p);

    logic               clear_i;
    logic               valid_i;
    logic               ready_o;
    logic [width_p-1:0] data_i;
    logic               valid_o;
    logic               ready_i;
    logic [sum_w-1:0]   sum_o;

    modport slave (
        input  clear_i, valid_i, data_i, ready_i,
        output ready_o, valid_o, sum_o
    );

    modport master (
        output clear_i, valid_i, data_i, ready_i,
        input  ready_o, valid_o, sum_o
    );

endinterface : product_accumulator_if

// File: rtl/product_accumulator_up_counter.sv
// -----------------------------------------------------------------------------
// up_counter
// Free-running up counter with synchronous clear (priority) and enable.
//   clk_i   : clock, rising edge
//   reset_i : asynchronous active-low reset
//   clear_i : synchronous clear to 0, wins over en_i
//   en_i    : increment by one
//   count_o : current count
// -----------------------------------------------------------------------------
module up_counter #(
    parameter int width_p = 2
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               clear_i,
    input  logic               en_i,
    output logic [width_p-1:0] count_o
);

    logic [width_p-1:0] count_q;
    logic [width_p-1:0] count_d;

    always_comb begin
        // NOTE: default first so every path assigns count_d -- no latch.
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule : up_counter

// File: rtl/product_accumulator.sv
// -----------------------------------------------------------------------------
// product_accumulator
// Sums count_p unsigned product terms of width_p bits and presents the total
// on a valid/ready output. The sum is width_p + $clog2(count_p) bits wide, so
// it can never wrap.
//   clk_i   : clock, rising edge
//   reset_i : asynchronous active-low reset; discards everything at once
//   bus     : product_accumulator_if.slave (clear, term input, sum output)
// ACCUM accepts terms (ready_o=1); DONE holds the sum (valid_o=1) until the
// consumer takes it or clear_i drops it.
// -----------------------------------------------------------------------------
module product_accumulator
    import product_accumulator_pkg::*;
#(
    parameter int width_p = 8,
    parameter int count_p = 4
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    product_accumulator_if.slave  bus
);

    localparam int sum_w = width_p + $clog2(count_p);
    localparam int cnt_w = $clog2(count_p);
    localparam logic [cnt_w-1:0] last_cnt = cnt_w'(count_p - 1);

    acc_state_e       state_q, state_d;
    logic [sum_w-1:0] acc_q, acc_d;
    logic [cnt_w-1:0] cnt;
    logic             in_hs;
    logic             last_term;
    logic             cnt_clear;

    assign bus.ready_o = (state_q == ACCUM);
    assign bus.valid_o = (state_q == DONE);
    assign bus.sum_o   = acc_q;

    assign in_hs     = bus.valid_i & bus.ready_o;
    assign last_term = (cnt == last_cnt);
    // Clearing on the final term keeps the count correct for any count_p,
    // not just powers of two where it would wrap naturally.
    assign cnt_clear = bus.clear_i | (in_hs & last_term);

    up_counter #(
        .width_p (cnt_w)
    ) u_cnt (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clear_i (cnt_clear),
        .en_i    (in_hs),
        .count_o (cnt)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        unique case (state_q)
            ACCUM: begin
                if (in_hs) begin
                    acc_d = acc_q + sum_w'(bus.data_i);
                    if (last_term) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (bus.ready_i) begin
                    acc_d   = '0;
                    state_d = ACCUM;
                end
            end
            default: begin
                state_d = ACCUM;
                acc_d   = '0;
            end
        endcase
        // Abort overrides every handshake, including a pending output.
        if (bus.clear_i) begin
            state_d = ACCUM;
            acc_d   = '0;
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q <= ACCUM;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
        end
    end

endmodule : product_accumulator

// File: tb/tb_product_accumulator.sv
// -----------------------------------------------------------------------------
// tb_product_accumulator
// Directed test of product_accumulator with width_p=8, count_p=4.
// Inputs change 1 time unit after a rising edge; outputs are sampled there.
// -----------------------------------------------------------------------------
module tb_product_accumulator;

    logic clk_i   = 1'b0;
    logic reset_i = 1'b0;
    int   n_cmp   = 0;
    int   n_err   = 0;
    int   out_hs  = 0;

    product_accumulator_if #(.width_p(8), .count_p(4)) bus ();

    product_accumulator #(
        .width_p (8),
        .count_p (4)
    ) dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .bus     (bus)
    );

    always #5 clk_i = ~clk_i;

    // Counts output handshakes seen by the DUT.
    always @(posedge clk_i) begin
        if (reset_i && bus.valid_o && bus.ready_i) out_hs = out_hs + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic feed(input logic [7:0] d);
        bus.valid_i = 1'b1;
        bus.data_i  = d;
        tick();
        bus.valid_i = 1'b0;
        bus.data_i  = 8'hxx;
    endtask

    // Feeds four terms; result must appear only after the fourth.
    task automatic group(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic [7:0] d, input int exp);
        logic [7:0] t [4];
        t[0] = a; t[1] = b; t[2] = c; t[3] = d;
        for (int i = 0; i < 3; i++) begin
            feed(t[i]);
            check({tag, "_pend_valid"}, 32'(bus.valid_o), 32'd0);
        end
        feed(t[3]);
        check({tag, "_valid"}, 32'(bus.valid_o), 32'd1);
        check({tag, "_ready"}, 32'(bus.ready_o), 32'd0);
        check({tag, "_sum"}, 32'(bus.sum_o), 32'(exp));
    endtask

    // Consumes a held sum and checks the return to ACCUM.
    task automatic drain(input string tag);
        bus.ready_i = 1'b1;
        tick();
        check({tag, "_drain_valid"}, 32'(bus.valid_o), 32'd0);
        check({tag, "_drain_ready"}, 32'(bus.ready_o), 32'd1);
        check({tag, "_drain_sum"}, 32'(bus.sum_o), 32'd0);
    endtask

    initial begin
        int hs_before;
        bus.clear_i = 1'b0;
        bus.valid_i = 1'b0;
        bus.data_i  = '0;
        bus.ready_i = 1'b1;

        // Reset state
        #1;
        check("rst_valid", 32'(bus.valid_o), 32'd0);
        check("rst_ready", 32'(bus.ready_o), 32'd1);
        check("rst_sum", 32'(bus.sum_o), 32'd0);
        tick();
        reset_i = 1'b1;
        tick();

        // Back-to-back 3,5,7,9 with ready_i high
        group("b2b", 8'd3, 8'd5, 8'd7, 8'd9, 24);
        tick();
        check("b2b_after_valid", 32'(bus.valid_o), 32'd0);
        check("b2b_after_sum", 32'(bus.sum_o), 32'd0);

        // Maximum terms, no wrap; then small group proves clear
        bus.ready_i = 1'b0;
        group("max", 8'd255, 8'd255, 8'd255, 8'd255, 1020);
        drain("max");
        bus.ready_i = 1'b0;
        group("ones", 8'd1, 8'd1, 8'd1, 8'd1, 4);
        drain("ones");

        // Backpressure: sum held, term 77 refused
        bus.ready_i = 1'b0;
        group("bp", 8'd1, 8'd2, 8'd3, 8'd4, 10);
        bus.valid_i = 1'b1;
        bus.data_i  = 8'd77;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_hold_valid", 32'(bus.valid_o), 32'd1);
            check("bp_hold_ready", 32'(bus.ready_o), 32'd0);
            check("bp_hold_sum", 32'(bus.sum_o), 32'd10);
        end
        bus.ready_i = 1'b1;   // term offered on the output-handshake cycle
        tick();
        bus.valid_i = 1'b0;
        check("bp_release_sum", 32'(bus.sum_o), 32'd0);
        check("bp_release_ready", 32'(bus.ready_o), 32'd1);
        bus.ready_i = 1'b0;
        group("bp_next", 8'd1, 8'd1, 8'd1, 8'd1, 4);
        drain("bp_next");

        // Idle cycles mid-group
        bus.ready_i = 1'b0;
        feed(8'd10);
        feed(8'd20);
        for (int i = 0; i < 2; i++) begin
            bus.data_i = 8'd99;
            tick();
            check("idle_sum", 32'(bus.sum_o), 32'd30);
            check("idle_valid", 32'(bus.valid_o), 32'd0);
        end
        feed(8'd30);
        check("idle_pend_valid", 32'(bus.valid_o), 32'd0);
        feed(8'd40);
        check("idle_valid_done", 32'(bus.valid_o), 32'd1);
        check("idle_sum_done", 32'(bus.sum_o), 32'd100);
        drain("idle");

        // Asynchronous reset between edges mid-group
        bus.ready_i = 1'b0;
        feed(8'd10);
        feed(8'd20);
        #1 reset_i = 1'b0;
        #1;
        check("areset_valid", 32'(bus.valid_o), 32'd0);
        check("areset_sum", 32'(bus.sum_o), 32'd0);
        check("areset_ready", 32'(bus.ready_o), 32'd1);
        #1 reset_i = 1'b1;
        group("post_rst", 8'd1, 8'd2, 8'd3, 8'd4, 10);
        drain("post_rst");

        // Clear mid-group and clear while holding a result
        bus.ready_i = 1'b0;
        hs_before = out_hs;
        feed(8'd3);
        feed(8'd5);
        bus.clear_i = 1'b1;
        tick();
        bus.clear_i = 1'b0;
        check("clr_part_sum", 32'(bus.sum_o), 32'd0);
        check("clr_part_ready", 32'(bus.ready_o), 32'd1);
        group("clr_grp", 8'd3, 8'd5, 8'd7, 8'd9, 24);
        bus.clear_i = 1'b1;
        tick();
        bus.clear_i = 1'b0;
        check("clr_done_valid", 32'(bus.valid_o), 32'd0);
        check("clr_done_sum", 32'(bus.sum_o), 32'd0);
        check("clr_no_out_hs", 32'(out_hs), 32'(hs_before));
        bus.ready_i = 1'b1;
        group("clr_next", 8'd2, 8'd2, 8'd2, 8'd2, 8);
        tick();
        check("clr_next_out_hs", 32'(out_hs), 32'(hs_before + 1));
        check("clr_next_valid", 32'(bus.valid_o), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_product_accumulator
